top_if: RTL
===========

TOP_IF -- requirements
Module: top_if

Interface
REQ-001 SHALL have parameter LENGTH_INSTRUCTION, default 32, instruction width in bits.
REQ-002 SHALL have parameter CANT_BITS_ADDR, default 11, PC and instruction-memory word-address width.
REQ-003 SHALL have parameter HALT_INSTRUCTION, default 32'hFFFFFFFF, encoding that stops fetch.
REQ-004 SHALL have parameter NOP_INSTRUCTION, default 32'h00000000, encoding injected as a bubble.
REQ-005 SHALL have port i_clock  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port i_soft_reset  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port i_enable_pipeline  input  1  global advance enable from the debug unit.
REQ-008 SHALL have port i_stall  input  1  hazard-unit stall; holds PC and IF/ID outputs.
REQ-009 SHALL have port i_branch_control  input  1  taken branch/jump from the decode stage.
REQ-010 SHALL have port i_branch_dir  input  CANT_BITS_ADDR  branch/jump target word address.
REQ-011 SHALL have port i_mem_write_en  input  1  program-load write strobe from the debug unit.
REQ-012 SHALL have port i_mem_write_addr  input  CANT_BITS_ADDR  program-load word address.
REQ-013 SHALL have port i_mem_write_data  input  LENGTH_INSTRUCTION  program-load word.
REQ-014 SHALL have port o_instruction  output  LENGTH_INSTRUCTION  registered IF/ID instruction.
REQ-015 SHALL have port o_out_adder_pc  output  CANT_BITS_ADDR  registered PC+1 of o_instruction.
REQ-016 SHALL have port o_pc  output  CANT_BITS_ADDR  current PC register, for debug readout.
REQ-017 SHALL have port o_halt_fetched  output  1  high while in state HALTED.

Function
REQ-018 SHALL hold a 2^CANT_BITS_ADDR x LENGTH_INSTRUCTION instruction memory, combinational read at o_pc, written on rising edge when i_mem_write_en=1, in any state.
REQ-019 SHALL implement states IDLE, RUN, HALTED; IDLE->RUN when i_enable_pipeline=1; RUN->HALTED when a fetch advances with mem[o_pc]==HALT_INSTRUCTION; HALTED exits only via reset.
REQ-020 SHALL, in RUN, define "advance" as i_enable_pipeline=1 and i_stall=0; no advance leaves PC, o_instruction, o_out_adder_pc unchanged.
REQ-021 SHALL, on advance, load o_instruction<=mem[o_pc] and o_out_adder_pc<=o_pc+1 (one-cycle fetch latency).
REQ-022 SHALL, on advance, update PC with priority: i_branch_control=1 -> i_branch_dir; else fetched word==HALT_INSTRUCTION -> hold; else o_pc+1.
REQ-023 SHALL wrap PC+1 modulo 2^CANT_BITS_ADDR (max address -> 0).
REQ-024 SHALL give i_stall priority over i_branch_control when both are high (branch ignored that cycle; decode re-presents it).
REQ-025 SHALL, when the HALT word is fetched, pass it to o_instruction once and then hold o_instruction at HALT_INSTRUCTION in HALTED.
REQ-026 SHALL, in IDLE and HALTED, ignore i_stall and i_branch_control and keep PC unchanged.

Reset
REQ-027 SHALL on i_soft_reset=1 at a rising edge set PC=0, o_instruction=NOP_INSTRUCTION, o_out_adder_pc=0, state=IDLE, o_halt_fetched=0, overriding all other inputs including mid-operation.
REQ-028 SHALL NOT clear instruction-memory contents on reset; a write coincident with reset is still performed.

Configuration
REQ-029 SHALL support macro IF_FLUSH_ON_BRANCH_EN: defined -> on an advance with i_branch_control=1, o_instruction<=NOP_INSTRUCTION (delay slot squashed); undefined -> the delay-slot word mem[o_pc] is passed normally.

Verification
REQ-030 SHALL cover: reset, load mem[0..3]=1,2,3,4, enable -> o_instruction 1,2,3,4 on successive cycles, o_out_adder_pc 1,2,3,4.
REQ-031 SHALL cover: i_stall=1 for 2 cycles at PC=2 -> o_pc stays 2, o_instruction stays 2 for both cycles, then resumes with 3.
REQ-032 SHALL cover: i_branch_control=1, i_branch_dir=0x100 at PC=5 -> next o_pc=0x100; o_instruction=mem[5] without macro, NOP with IF_FLUSH_ON_BRANCH_EN.
REQ-033 SHALL cover: i_stall=1 and i_branch_control=1 together -> PC unchanged; branch taken next cycle once stall drops.
REQ-034 SHALL cover: mem[6]=32'hFFFFFFFF -> o_instruction=FFFFFFFF, o_halt_fetched=1, o_pc stays 6 for 10 cycles; reset -> o_pc=0, IDLE.
REQ-035 SHALL cover: PC=0x7FF with no branch -> next o_pc=0x000, o_out_adder_pc=0x000.

Source files
------------

// File: rtl/top_if.sv
// -----------------------------------------------------------------------------
// top_if : instruction-fetch stage with on-chip instruction memory.
//
// Holds a 2^CANT_BITS_ADDR x LENGTH_INSTRUCTION program memory that is loaded
// by the debug unit, a program counter, and the IF/ID pipeline register.
// A small IDLE/RUN/HALTED controller gates fetch. Fetching the HALT word
// stops the PC and parks the stage in HALTED until a soft reset.
//
// Configuration macro:
//   IF_FLUSH_ON_BRANCH_EN  defined   -> the delay-slot word fetched alongside a
//                                       taken branch is replaced by a NOP
//                          undefined -> the delay-slot word passes normally
//
// Ports:
//   i_clock            single clock, rising edge
//   i_soft_reset       synchronous active-high reset (memory keeps contents)
//   i_enable_pipeline  global advance enable from the debug unit
//   i_stall            hazard stall; holds PC and IF/ID register
//   i_branch_control   taken branch/jump from decode
//   i_branch_dir       branch/jump target word address
//   i_mem_write_en     program-load write strobe
//   i_mem_write_addr   program-load word address
//   i_mem_write_data   program-load word
//   o_instruction      registered IF/ID instruction
//   o_out_adder_pc     registered PC+1 belonging to o_instruction
//   o_pc               current PC register
//   o_halt_fetched     high while in HALTED
// -----------------------------------------------------------------------------
module top_if #(
  parameter int unsigned                   LENGTH_INSTRUCTION = 32,
  parameter int unsigned                   CANT_BITS_ADDR     = 11,
  parameter logic [LENGTH_INSTRUCTION-1:0] HALT_INSTRUCTION   = 32'hFFFFFFFF,
  parameter logic [LENGTH_INSTRUCTION-1:0] NOP_INSTRUCTION    = 32'h00000000
) (
  input  logic                          i_clock,
  input  logic                          i_soft_reset,
  input  logic                          i_enable_pipeline,
  input  logic                          i_stall,
  input  logic                          i_branch_control,
  input  logic [CANT_BITS_ADDR-1:0]     i_branch_dir,
  input  logic                          i_mem_write_en,
  input  logic [CANT_BITS_ADDR-1:0]     i_mem_write_addr,
  input  logic [LENGTH_INSTRUCTION-1:0] i_mem_write_data,
  output logic [LENGTH_INSTRUCTION-1:0] o_instruction,
  output logic [CANT_BITS_ADDR-1:0]     o_out_adder_pc,
  output logic [CANT_BITS_ADDR-1:0]     o_pc,
  output logic                          o_halt_fetched
);

  localparam int unsigned MEM_DEPTH = 2 ** CANT_BITS_ADDR;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  state_e                          state_q;
  logic [CANT_BITS_ADDR-1:0]       pc_q;
  logic [CANT_BITS_ADDR-1:0]       pc_d;
  logic [LENGTH_INSTRUCTION-1:0]   instr_q;
  logic [LENGTH_INSTRUCTION-1:0]   instr_d;
  logic [CANT_BITS_ADDR-1:0]       adder_q;
  logic                            halt_q;

  logic [LENGTH_INSTRUCTION-1:0]   mem [MEM_DEPTH];
  logic [LENGTH_INSTRUCTION-1:0]   fetch_c;
  logic [CANT_BITS_ADDR-1:0]       pc_inc_c;
  logic                            advance_c;
  logic                            is_halt_c;

  // Program load port; active in every state and not affected by reset.
  always_ff @(posedge i_clock) begin
    if (i_mem_write_en) begin
      mem[i_mem_write_addr] <= i_mem_write_data;
    end
  end

  // Combinational read at the current PC.
  assign fetch_c   = mem[pc_q];
  assign is_halt_c = (fetch_c == HALT_INSTRUCTION);
  // Natural width wrap: max address + 1 rolls over to 0.
  assign pc_inc_c  = pc_q + CANT_BITS_ADDR'(1);
  // Stall dominates; a branch seen during a stall is re-presented by decode.
  assign advance_c = i_enable_pipeline && !i_stall;

  // Next PC and next IF/ID word for an advancing RUN cycle.
  always_comb begin
    pc_d    = pc_inc_c;
    instr_d = fetch_c;
    if (i_branch_control) begin
      pc_d = i_branch_dir;
`ifdef IF_FLUSH_ON_BRANCH_EN
      instr_d = NOP_INSTRUCTION;
`endif
    end else if (is_halt_c) begin
      pc_d = pc_q;
    end
  end

  // Fetch controller and IF/ID register.
  always_ff @(posedge i_clock) begin
    if (i_soft_reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      instr_q <= NOP_INSTRUCTION;
      adder_q <= '0;
      halt_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_enable_pipeline) begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (advance_c) begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            adder_q <= pc_inc_c;
            if (is_halt_c) begin
              state_q <= ST_HALTED;
              halt_q  <= 1'b1;
            end
          end
        end
        ST_HALTED: begin
          // PC frozen; keep presenting the HALT word downstream.
          instr_q <= HALT_INSTRUCTION;
          halt_q  <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          halt_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_pc           = pc_q;
  assign o_instruction  = instr_q;
  assign o_out_adder_pc = adder_q;
  assign o_halt_fetched = halt_q;

endmodule
